// File: rtl/argmax_unit_pkg.sv
// Shared constants for the neural_net output stage.
// Also holds the argmax scan state encoding.
package argmax_unit_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int NEURONS_NUM_L4 = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } argmax_state_e;

endpackage

// File: rtl/argmax_unit.sv
// Serial signed argmax over the last layer's output vector.
// Latches the winning index/value and raises a sticky interrupt.
module argmax_unit
    import argmax_unit_pkg::*;
#(
    parameter int NUM_INPUTS = argmax_unit_pkg::NEURONS_NUM_L4,
    parameter int DATA_WIDTH = argmax_unit_pkg::DATA_WIDTH,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [IDX_W-1:0]                 out_index,
    output logic [DATA_WIDTH-1:0]            out_max,
    output logic                             out_valid,
    input  logic                             intr_clr,
    output logic                             intr
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    argmax_state_e r_state;
    argmax_state_e w_next;

    logic signed [DATA_WIDTH-1:0] r_buf [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] r_max;
    logic [IDX_W-1:0]             r_idx;
    logic [IDX_W-1:0]             r_cnt;
    logic [IDX_W-1:0]             r_oidx;
    logic [DATA_WIDTH-1:0]        r_omax;
    logic                         r_ovalid;
    logic                         r_intr;

    logic                         w_accept;
    logic                         w_done;
    logic signed [DATA_WIDTH-1:0] w_elem;
    logic                         w_gt;
    logic signed [DATA_WIDTH-1:0] w_new_max;
    logic [IDX_W-1:0]             w_new_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_cnt == LAST) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Strict greater-than keeps the lower index on ties.
    assign w_elem    = r_buf[r_cnt];
    assign w_gt      = (w_elem > r_max);
    assign w_new_max = w_gt ? w_elem : r_max;
    assign w_new_idx = w_gt ? r_cnt : r_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_buf[i] <= '0;
            end
            r_max    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_oidx   <= '0;
            r_omax   <= '0;
            r_ovalid <= 1'b0;
            r_intr   <= 1'b0;
        end else begin
            r_ovalid <= w_done;
            if (w_accept) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    r_buf[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
                r_max <= in_data[0 +: DATA_WIDTH];
                r_idx <= '0;
                r_cnt <= ONE;
            end else if (r_state == S_SCAN) begin
                r_max <= w_new_max;
                r_idx <= w_new_idx;
                if (w_done) begin
                    r_oidx <= w_new_idx;
                    r_omax <= w_new_max;
                end else begin
                    r_cnt <= r_cnt + ONE;
                end
            end
            if (w_done) begin
                r_intr <= 1'b1;
            end else if (intr_clr) begin
                r_intr <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_index = r_oidx;
    assign out_max   = r_omax;
    assign out_valid = r_ovalid;
    assign intr      = r_intr;

endmodule

// File: tb/tb_argmax_unit.sv
// Directed bench for argmax_unit with N=10, 16-bit activations.
// Outputs are sampled on the falling edge.
module tb_argmax_unit;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic            clk;
    logic            reset_n;
    logic [N*DW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   out_index;
    logic [DW-1:0]   out_max;
    logic            out_valid;
    logic            intr_clr;
    logic            intr;

    int passed;
    int total;
    int v [N];

    argmax_unit #(
        .NUM_INPUTS(N),
        .DATA_WIDTH(DW),
        .IDX_W     (IW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_index(out_index),
        .out_max  (out_max),
        .out_valid(out_valid),
        .intr_clr (intr_clr),
        .intr     (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] pk();
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*DW +: DW] = DW'(v[i]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input int ei,
                           input logic [DW-1:0] em);
        int lat;
        in_data  = pk();
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_idx"}, 32'(out_index), 32'(ei));
        check({tag, "_max"}, 32'(out_max), 32'(em));
        check({tag, "_intr"}, 32'(intr), 32'd1);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        cyc();
        check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int pulses;
        passed   = 0;
        total    = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        intr_clr = 1'b0;
        in_data  = '0;
        @(negedge clk);
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_idx", 32'(out_index), 32'd0);
        check("rst_max", 32'(out_max), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        reset_n = 1'b1;
        cyc();

        v = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        run_vec("basic", 5, 16'd9);

        intr_clr = 1'b1;
        cyc();
        intr_clr = 1'b0;
        check("clr", 32'(intr), 32'd0);

        v = '{-5, -2, -2, -7, -9, -3, -8, -4, -6, -10};
        run_vec("neg", 1, 16'hFFFE);

        v = '{-32768, -32768, -32768, -32768, -32768,
              -32768, -32768, -32768, -32768, 32767};
        run_vec("ext9", 9, 16'h7FFF);
        v = '{32767, -32768, -32768, -32768, -32768,
              -32768, -32768, -32768, -32768, -32768};
        run_vec("ext0", 0, 16'h7FFF);

        // Back-to-back: A (max idx 2) then B (max idx 6)
        v = '{1, 2, 50, 3, 4, 5, 6, 7, 8, 9};
        in_data  = pk();
        in_valid = 1'b1;
        cyc();
        v = '{1, 2, 3, 4, 5, 6, 70, 7, 8, 9};
        in_data = pk();
        for (int k = 1; k < 9; k++) cyc();
        cyc();
        check("b2b_a_ov", 32'(out_valid), 32'd1);
        check("b2b_a_rdy", 32'(in_ready), 32'd1);
        check("b2b_a_idx", 32'(out_index), 32'd2);
        check("b2b_a_max", 32'(out_max), 32'd50);
        cyc();
        in_valid = 1'b0;
        check("b2b_b_acc", 32'(in_ready), 32'd0);
        check("b2b_intr", 32'(intr), 32'd1);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) pulses++;
            cyc();
        end
        check("b2b_nopulse", 32'(pulses), 32'd0);
        intr_clr = 1'b1;
        cyc();
        check("b2b_b_ov", 32'(out_valid), 32'd1);
        check("b2b_b_idx", 32'(out_index), 32'd6);
        check("b2b_b_max", 32'(out_max), 32'd70);
        check("set_wins", 32'(intr), 32'd1);
        cyc();
        intr_clr = 1'b0;
        check("clr_after", 32'(intr), 32'd0);

        // Mid-scan disturbance
        v = '{0, 0, 0, 40, 0, 0, 0, 0, 0, 0};
        in_data  = pk();
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 99, 0};
        in_data = pk();
        reset_n = 1'b0;
        #1;
        check("mid_rdy", 32'(in_ready), 32'd1);
        check("mid_idx", 32'(out_index), 32'd0);
        check("mid_max", 32'(out_max), 32'd0);
        check("mid_ov", 32'(out_valid), 32'd0);
        check("mid_intr", 32'(intr), 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (out_valid) pulses++;
        end
        check("mid_nopulse", 32'(pulses), 32'd0);

        v = '{0, 1, 2, 3, 4, 5, 6, 100, 7, 8};
        run_vec("fresh", 7, 16'd100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
